// File: rtl/moving_average_pkg.sv
// rtl/moving_average_pkg.sv - shared widths, rounding helpers and sample types for the moving-average blocks
package moving_average_pkg;

    // Rounding mode selectors for the ROUND parameter
    localparam int ROUND_FLOOR   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Default channel configuration used by the channelised wrappers
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_LOG2_DEPTH = 2;

    // Accumulator is wide enough to hold DEPTH full-scale samples without overflow
    function automatic int acc_width(input int width, input int log2_depth);
        return width + log2_depth;
    endfunction

    // Half an LSB of the divided result, added before the shift when rounding
    function automatic int round_const(input int round, input int log2_depth);
        return (round == ROUND_HALF_UP) ? (1 << (log2_depth - 1)) : 0;
    endfunction

    typedef logic signed [DEFAULT_WIDTH-1:0] sample_t;
    typedef logic signed [DEFAULT_WIDTH+DEFAULT_LOG2_DEPTH-1:0] acc_t;

endpackage

// File: rtl/moving_average_n_if.sv
// rtl/moving_average_n_if.sv - sample in / average out stream bundle
interface moving_average_n_if #(
    parameter int WIDTH = 8
);
    logic signed [WIDTH-1:0] input_0;
    logic                    input_valid;
    logic signed [WIDTH-1:0] output_0;
    logic                    output_valid;

    modport master (
        output input_0,
        output input_valid,
        input  output_0,
        input  output_valid
    );

    modport slave (
        input  input_0,
        input  input_valid,
        output output_0,
        output output_valid
    );
endinterface

// File: rtl/moving_average_ring.sv
// rtl/moving_average_ring.sv - sample ring buffer with fill count and read-before-write oldest tap
module moving_average_ring
    import moving_average_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] oldest,
    output logic [LOG2_DEPTH:0]     count
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);

    logic [LOG2_DEPTH-1:0]   wr_ptr;
    logic signed [WIDTH-1:0] mem [DEPTH];

    // Slots are only meaningful once the window has filled; before that the leaving sample is zero
    assign oldest = (count == FULL_CNT) ? mem[wr_ptr] : '0;

    // Write pointer wraps naturally; fill count saturates at DEPTH
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL_CNT)
                count <= count + 1'b1;
        end
    end

    // Storage is not reset; the fill count guarantees no unwritten slot is ever read
    always_ff @(posedge clk) begin
        if (accept && !clear && !rst)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/moving_average_n.sv
// rtl/moving_average_n.sv - streaming boxcar average over 2^LOG2_DEPTH signed samples
module moving_average_n
    import moving_average_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int ROUND      = 0
) (
    input  logic               system1000,
    input  logic               system1000_rst,
    moving_average_n_if.slave  stream,
    input  logic               clear,
    output logic               window_full
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int AW    = acc_width(WIDTH, LOG2_DEPTH);
    localparam logic signed [AW-1:0] RND = AW'(round_const(ROUND, LOG2_DEPTH));
    localparam logic [LOG2_DEPTH:0] FULL_CNT   = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] ALMOST_CNT = (LOG2_DEPTH + 1)'(DEPTH - 1);

    logic                    accept;
    logic signed [WIDTH-1:0] oldest;
    logic [LOG2_DEPTH:0]     count;
    logic signed [AW-1:0]    sum;
    logic signed [AW-1:0]    in_ext;
    logic signed [AW-1:0]    old_ext;
    logic signed [AW-1:0]    sum_next;
    logic signed [AW-1:0]    rounded;
    logic                    full_next;

    assign accept    = stream.input_valid && !clear;
    assign in_ext    = {{LOG2_DEPTH{stream.input_0[WIDTH-1]}}, stream.input_0};
    assign old_ext   = {{LOG2_DEPTH{oldest[WIDTH-1]}}, oldest};
    assign sum_next  = sum + in_ext - old_ext;
    assign rounded   = sum_next + RND;
    assign full_next = (count == FULL_CNT) || (count == ALMOST_CNT);

    moving_average_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk    (system1000),
        .rst    (system1000_rst),
        .accept (accept),
        .clear  (clear),
        .din    (stream.input_0),
        .oldest (oldest),
        .count  (count)
    );

    // Running sum and registered average; reset beats clear, clear beats a new sample
    always_ff @(posedge system1000) begin
        if (system1000_rst || clear) begin
            sum                 <= '0;
            stream.output_0     <= '0;
            stream.output_valid <= 1'b0;
            window_full         <= 1'b0;
        end else if (accept) begin
            sum                 <= sum_next;
            stream.output_0     <= WIDTH'(rounded >>> LOG2_DEPTH);
            stream.output_valid <= 1'b1;
            window_full         <= full_next;
        end else begin
            stream.output_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_moving_average_n.sv
// tb/tb_moving_average_n.sv - directed bench for moving_average_n in floor and round modes
module tb_moving_average_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic full0, full1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    moving_average_n_if #(.WIDTH(8)) if0 ();
    moving_average_n_if #(.WIDTH(8)) if1 ();

    moving_average_n #(.WIDTH(8), .LOG2_DEPTH(2), .ROUND(0)) u_floor (
        .system1000     (clk),
        .system1000_rst (rst),
        .stream         (if0.slave),
        .clear          (clear),
        .window_full    (full0)
    );

    moving_average_n #(.WIDTH(8), .LOG2_DEPTH(2), .ROUND(1)) u_round (
        .system1000     (clk),
        .system1000_rst (rst),
        .stream         (if1.slave),
        .clear          (clear),
        .window_full    (full1)
    );

    task automatic drive(input logic v, input logic signed [7:0] d, input logic c);
        if0.input_valid = v;
        if0.input_0     = d;
        if1.input_valid = v;
        if1.input_0     = d;
        clear           = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'sd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (if0.output_0 !== 8'sd0 || if0.output_valid !== 1'b0 || full0 !== 1'b0 ||
            if1.output_0 !== 8'sd0 || if1.output_valid !== 1'b0 || full1 !== 1'b0) begin
            fails++;
            $display("FAIL reset out0=%0d v0=%b f0=%b out1=%0d v1=%b f1=%b required all zero",
                     if0.output_0, if0.output_valid, full0, if1.output_0, if1.output_valid, full1);
        end
    endtask

    task automatic test_ramp();
        logic signed [7:0] din [5]  = '{8'sd4, 8'sd8, 8'sd12, 8'sd16, 8'sd20};
        logic signed [7:0] exp_o [5] = '{8'sd1, 8'sd3, 8'sd6, 8'sd10, 8'sd14};
        logic exp_f [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, din[i], 1'b0);
            tests++;
            if (if0.output_0 !== exp_o[i] || if0.output_valid !== 1'b1 || full0 !== exp_f[i]) begin
                fails++;
                $display("FAIL ramp[%0d] out=%0d valid=%b full=%b required out=%0d valid=1 full=%b",
                         i, if0.output_0, if0.output_valid, full0, exp_o[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic signed [7:0] exp_o [9] = '{8'sd31, 8'sd63, 8'sd95, 8'sd127, 8'sd127,
                                         8'sd63, -8'sd1, -8'sd65, -8'sd128};
        logic signed [7:0] d;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            d = (i < 5) ? 8'sd127 : -8'sd128;
            drive(1'b1, d, 1'b0);
            tests++;
            if (if0.output_0 !== exp_o[i] || if0.output_valid !== 1'b1) begin
                fails++;
                $display("FAIL extremes[%0d] out=%0d valid=%b required out=%0d valid=1",
                         i, if0.output_0, if0.output_valid, exp_o[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic signed [7:0] din [5]  = '{-8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2};
        logic signed [7:0] exp_f [5] = '{-8'sd1, 8'sd0, 8'sd0, 8'sd1, 8'sd2};
        logic signed [7:0] exp_r [5] = '{8'sd0, 8'sd0, 8'sd1, 8'sd1, 8'sd2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, din[i], 1'b0);
            tests++;
            if (if0.output_0 !== exp_f[i] || if1.output_0 !== exp_r[i]) begin
                fails++;
                $display("FAIL rounding[%0d] floor=%0d round=%0d required floor=%0d round=%0d",
                         i, if0.output_0, if1.output_0, exp_f[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_idle();
        do_reset();
        drive(1'b1, 8'sd4, 1'b0);
        drive(1'b1, 8'sd8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'sd99, 1'b0);
            tests++;
            if (if0.output_0 !== 8'sd3 || if0.output_valid !== 1'b0) begin
                fails++;
                $display("FAIL idle[%0d] out=%0d valid=%b required out=3 valid=0",
                         i, if0.output_0, if0.output_valid);
            end
        end
        drive(1'b1, 8'sd12, 1'b0);
        tests++;
        if (if0.output_0 !== 8'sd6 || if0.output_valid !== 1'b1) begin
            fails++;
            $display("FAIL idle_resume out=%0d valid=%b required out=6 valid=1",
                     if0.output_0, if0.output_valid);
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1'b1, 8'sd8, 1'b0);
        tests++;
        if (if0.output_0 !== 8'sd8 || full0 !== 1'b1) begin
            fails++;
            $display("FAIL clear_fill out=%0d full=%b required out=8 full=1", if0.output_0, full0);
        end
        drive(1'b1, 8'sd100, 1'b1);
        tests++;
        if (if0.output_0 !== 8'sd0 || if0.output_valid !== 1'b0 || full0 !== 1'b0) begin
            fails++;
            $display("FAIL clear out=%0d valid=%b full=%b required out=0 valid=0 full=0",
                     if0.output_0, if0.output_valid, full0);
        end
        drive(1'b1, 8'sd4, 1'b0);
        tests++;
        if (if0.output_0 !== 8'sd1 || if0.output_valid !== 1'b1 || full0 !== 1'b0) begin
            fails++;
            $display("FAIL clear_after out=%0d valid=%b full=%b required out=1 valid=1 full=0",
                     if0.output_0, if0.output_valid, full0);
        end
    endtask

    task automatic test_reset_mid();
        logic signed [7:0] din [4]  = '{8'sd4, 8'sd8, 8'sd12, 8'sd16};
        logic signed [7:0] exp_o [4] = '{8'sd1, 8'sd3, 8'sd6, 8'sd10};
        logic exp_f [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++)
            drive(1'b1, 8'sd40, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'sd50, 1'b0);
        rst = 1'b0;
        tests++;
        if (if0.output_0 !== 8'sd0 || if0.output_valid !== 1'b0 || full0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid out=%0d valid=%b full=%b required out=0 valid=0 full=0",
                     if0.output_0, if0.output_valid, full0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, din[i], 1'b0);
            tests++;
            if (if0.output_0 !== exp_o[i] || if0.output_valid !== 1'b1 || full0 !== exp_f[i]) begin
                fails++;
                $display("FAIL reset_mid_seq[%0d] out=%0d valid=%b full=%b required out=%0d valid=1 full=%b",
                         i, if0.output_0, if0.output_valid, full0, exp_o[i], exp_f[i]);
            end
        end
    endtask

    initial begin
        if0.input_valid = 1'b0;
        if0.input_0     = '0;
        if1.input_valid = 1'b0;
        if1.input_0     = '0;
        test_reset();
        test_ramp();
        test_extremes();
        test_rounding();
        test_idle();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
